// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: instruction codes, register ids,
// status codes and controller state.
package pipe_ctrl_pkg;

   localparam logic [3:0] HALT   = 4'h0;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] RRMOVQ = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

   localparam logic [3:0] RNONE  = 4'hF;

   localparam logic [3:0] AOK    = 4'd1;
   localparam logic [3:0] HLT    = 4'd2;
   localparam logic [3:0] ADR    = 4'd3;
   localparam logic [3:0] INS    = 4'd4;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   function automatic logic is_exc(input logic [3:0] stat);
      return (stat == HLT) || (stat == ADR) || (stat == INS);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and its controller. cnt_load/cnt_load_val
// preset all three performance counters (bring-up and wrap testing).
interface pipe_ctrl_if;
   logic [3:0]  D_icode;
   logic [3:0]  E_icode;
   logic [3:0]  M_icode;
   logic [3:0]  d_srcA;
   logic [3:0]  d_srcB;
   logic [3:0]  E_dstM;
   logic        e_Cnd;
   logic [3:0]  m_stat;
   logic [3:0]  W_stat;
   logic        cnt_load;
   logic [31:0] cnt_load_val;

   logic        F_stall;
   logic        D_stall;
   logic        D_bubble;
   logic        E_bubble;
   logic        M_bubble;
   logic        W_stall;
   logic        set_cc;
   logic [3:0]  cpu_stat;
   logic        halted;
   logic [31:0] cyc_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] mispred_cnt;

   modport master (
      output D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd,
             m_stat, W_stat, cnt_load, cnt_load_val,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
             cpu_stat, halted, cyc_cnt, stall_cnt, mispred_cnt
   );

   modport slave (
      input  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd,
             m_stat, W_stat, cnt_load, cnt_load_val,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
             cpu_stat, halted, cyc_cnt, stall_cnt, mispred_cnt
   );
endinterface

// File: rtl/pipe_hazard.sv
// Combinational hazard detection; produces the pipeline register controls that
// apply while the processor is running or draining.
module pipe_hazard
   import pipe_ctrl_pkg::*;
(
   input  logic [3:0] D_icode,
   input  logic [3:0] E_icode,
   input  logic [3:0] M_icode,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   input  logic [3:0] E_dstM,
   input  logic       e_Cnd,
   input  logic [3:0] m_stat,
   input  logic [3:0] W_stat,
   output logic       mispred,
   output logic       F_stall,
   output logic       D_stall,
   output logic       D_bubble,
   output logic       E_bubble,
   output logic       M_bubble,
   output logic       W_stall,
   output logic       set_cc
);
   logic load_use;
   logic ret_haz;
   logic exc_m;
   logic exc_w;

   // RNONE is never a real destination, so it must not match an unused source
   assign load_use = ((E_icode == MRMOVQ) || (E_icode == POPQ)) && (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign ret_haz  = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);
   assign mispred  = (E_icode == JXX) && !e_Cnd;
   assign exc_m    = is_exc(m_stat);
   assign exc_w    = is_exc(W_stat);

   assign F_stall  = load_use | ret_haz;
   assign D_stall  = load_use;
   // load/use wins over ret: D holds, so it must not also be bubbled
   assign D_bubble = mispred | (ret_haz & ~load_use);
   assign E_bubble = mispred | load_use;
   assign M_bubble = exc_m | exc_w;
   assign W_stall  = exc_w;
   assign set_cc   = (E_icode == OPQ) & ~exc_m & ~exc_w;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: run/drain/halt sequencing, processor status and
// performance counters around the pipe_hazard equations.
//
//   state  | meaning
//   RUN    | normal execution, hazard controls active
//   DRAIN  | exception seen in M, waiting for it to reach W
//   HALTED | exception retired; pipeline frozen until rst
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);
   state_t      state;
   logic [3:0]  cpu_stat;
   logic        halted;
   logic [31:0] cyc_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] mispred_cnt;

   logic h_f_stall;
   logic h_d_stall;
   logic h_d_bubble;
   logic h_e_bubble;
   logic h_m_bubble;
   logic h_w_stall;
   logic h_set_cc;
   logic mispred;

   pipe_hazard u_hazard (
      .D_icode  (bus.D_icode),
      .E_icode  (bus.E_icode),
      .M_icode  (bus.M_icode),
      .d_srcA   (bus.d_srcA),
      .d_srcB   (bus.d_srcB),
      .E_dstM   (bus.E_dstM),
      .e_Cnd    (bus.e_Cnd),
      .m_stat   (bus.m_stat),
      .W_stat   (bus.W_stat),
      .mispred  (mispred),
      .F_stall  (h_f_stall),
      .D_stall  (h_d_stall),
      .D_bubble (h_d_bubble),
      .E_bubble (h_e_bubble),
      .M_bubble (h_m_bubble),
      .W_stall  (h_w_stall),
      .set_cc   (h_set_cc)
   );

   always_comb begin
      bus.F_stall  = h_f_stall;
      bus.D_stall  = h_d_stall;
      bus.D_bubble = h_d_bubble;
      bus.E_bubble = h_e_bubble;
      bus.M_bubble = h_m_bubble;
      bus.W_stall  = h_w_stall;
      bus.set_cc   = h_set_cc;
      if (state == HALTED) begin
         bus.F_stall  = 1'b1;
         bus.D_stall  = 1'b1;
         bus.D_bubble = 1'b0;
         bus.E_bubble = 1'b0;
         bus.M_bubble = 1'b0;
         bus.W_stall  = 1'b1;
         bus.set_cc   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         cpu_stat <= AOK;
         halted   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (is_exc(bus.W_stat)) begin
                  state    <= HALTED;
                  cpu_stat <= bus.W_stat;
                  halted   <= 1'b1;
               end else if (is_exc(bus.m_stat)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (is_exc(bus.W_stat)) begin
                  state    <= HALTED;
                  cpu_stat <= bus.W_stat;
                  halted   <= 1'b1;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state    <= RUN;
               cpu_stat <= AOK;
               halted   <= 1'b0;
            end
         endcase
      end
   end

   // The edge leaving RUN/DRAIN for HALTED still counts; HALTED cycles do not
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt     <= '0;
         stall_cnt   <= '0;
         mispred_cnt <= '0;
      end else if (bus.cnt_load) begin
         cyc_cnt     <= bus.cnt_load_val;
         stall_cnt   <= bus.cnt_load_val;
         mispred_cnt <= bus.cnt_load_val;
      end else if (state != HALTED) begin
         cyc_cnt     <= cyc_cnt + 32'd1;
         stall_cnt   <= stall_cnt + {31'd0, h_f_stall};
         mispred_cnt <= mispred_cnt + {31'd0, mispred};
      end
   end

   assign bus.cpu_stat    = cpu_stat;
   assign bus.halted      = halted;
   assign bus.cyc_cnt     = cyc_cnt;
   assign bus.stall_cnt   = stall_cnt;
   assign bus.mispred_cnt = mispred_cnt;

endmodule
